// File: rtl/vga_sync_timing_if.sv
// Timing bundle from the VGA pixel-timing generator to the RGB pipeline and overlay generators.
// master drives the timing; slave is the consumer side.
interface vga_sync_timing_if;
  logic       hsync;
  logic       vsync;
  logic       video_activado;
  logic       instante_pulso;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_end;
  logic [7:0] frame_count;

  modport master (
    output hsync,
    output vsync,
    output video_activado,
    output instante_pulso,
    output pixel_x,
    output pixel_y,
    output frame_end,
    output frame_count
  );

  modport slave (
    input hsync,
    input vsync,
    input video_activado,
    input instante_pulso,
    input pixel_x,
    input pixel_y,
    input frame_end,
    input frame_count
  );
endinterface

// File: rtl/vga_sync_timing.sv
// 640x480@60 VGA pixel-timing generator: pixel-rate enable, h/v counters, registered syncs.
// Define VGA_SYNC_FRAME_COUNT_EN to build the 8-bit frame counter; otherwise frame_count is 0.
module vga_sync_timing #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic               clk,
  input  logic               reset,
  vga_sync_timing_if.master  bus
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [TICK_W-1:0] r_tick;
  logic [TICK_W-1:0] w_tick_d;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic [9:0]        w_x_d;
  logic [9:0]        w_y_d;
  logic              r_hsync;
  logic              r_vsync;
  logic              w_hsync_d;
  logic              w_vsync_d;
  logic              w_pulse;
  logic              w_frame_end;

  assign w_pulse     = (r_tick == TICK_LAST);
  assign w_frame_end = w_pulse && (r_x == H_LAST) && (r_y == V_LAST);

  always_comb begin
    w_tick_d = w_pulse ? '0 : r_tick + TICK_W'(1);
    w_x_d    = r_x;
    w_y_d    = r_y;
    if (w_pulse) begin
      if (r_x == H_LAST) begin
        w_x_d = '0;
        w_y_d = (r_y == V_LAST) ? '0 : r_y + 10'd1;
      end else begin
        w_x_d = r_x + 10'd1;
      end
    end
  end

  // Syncs decode the next-state counters so they land on the same edge as pixel_x/pixel_y.
  always_comb begin
    w_hsync_d = !((w_x_d >= HS_FIRST) && (w_x_d <= HS_LAST));
    w_vsync_d = !((w_y_d >= VS_FIRST) && (w_y_d <= VS_LAST));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_tick  <= w_tick_d;
      r_x     <= w_x_d;
      r_y     <= w_y_d;
      r_hsync <= w_hsync_d;
      r_vsync <= w_vsync_d;
    end
  end

  assign bus.hsync          = r_hsync;
  assign bus.vsync          = r_vsync;
  assign bus.instante_pulso = w_pulse;
  assign bus.pixel_x        = r_x;
  assign bus.pixel_y        = r_y;
  assign bus.frame_end      = w_frame_end;
  assign bus.video_activado = (r_x < H_VIS) && (r_y < V_VIS);

`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic [7:0] r_frame_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_count <= '0;
    end else if (w_frame_end) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign bus.frame_count = r_frame_count;
`else
  assign bus.frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_timing.sv
// Randomized bench for vga_sync_timing on a shrunken timing set; expectations come from an
// arithmetic model of elapsed clocks since reset release, checked by a negedge monitor.
module tb_vga_sync_timing;

  localparam int unsigned TD = 3;
  localparam int unsigned HD = 4;
  localparam int unsigned HF = 1;
  localparam int unsigned HS = 2;
  localparam int unsigned HB = 1;
  localparam int unsigned VD = 2;
  localparam int unsigned VF = 1;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 1;
  localparam int unsigned HT = HD + HF + HS + HB;
  localparam int unsigned VT = VD + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  vga_sync_timing_if u_if ();

  vga_sync_timing #(
    .TICK_DIV  (TD),
    .H_DISPLAY (HD),
    .H_FRONT   (HF),
    .H_SYNC    (HS),
    .H_BACK    (HB),
    .V_DISPLAY (VD),
    .V_FRONT   (VF),
    .V_SYNC    (VS),
    .V_BACK    (VB)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       va;
    logic       tick;
    logic       fe;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] fc;
  } exp_t;

  exp_t            q[$];
  int unsigned     checks   = 0;
  int unsigned     failures = 0;
  longint unsigned n        = 0;  // clock edges seen since reset release
  exp_t            m_exp;
  exp_t            m_act;

  // Everything follows from how many pixel ticks have elapsed since reset release.
  function automatic exp_t model(input longint unsigned edges);
    exp_t            e;
    longint unsigned t = edges / TD;
    longint unsigned c = edges % TD;
    longint unsigned p = t % FRAME;
    int unsigned     x = int'(p % HT);
    int unsigned     y = int'(p / HT);
    e.x    = 10'(x);
    e.y    = 10'(y);
    e.tick = (c == TD - 1);
    e.hs   = !(x >= HD + HF && x < HD + HF + HS);
    e.vs   = !(y >= VD + VF && y < VD + VF + VS);
    e.va   = (x < HD) && (y < VD);
    e.fe   = e.tick && (p == FRAME - 1);
`ifdef VGA_SYNC_FRAME_COUNT_EN
    e.fc   = 8'((t / FRAME) % 256);
`else
    e.fc   = 8'd0;
`endif
    return e;
  endfunction

  task automatic step(input bit do_assert, input bit do_release);
    @(posedge clk);
    #1;
    if (reset) n++;
    if (do_assert) begin
      #($urandom_range(0, 2));
      reset = 1'b0;
      n     = 0;
    end
    q.push_back(model(n));
    @(negedge clk);
    #2;
    if (do_release) reset = 1'b1;
  endtask

  task automatic run(input int unsigned k);
    repeat (k) step(1'b0, 1'b0);
  endtask

  task automatic reset_pulse(input int unsigned hold);
    step(1'b1, 1'b0);
    repeat (hold) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      m_exp = q.pop_front();
      m_act = '{hs: u_if.hsync, vs: u_if.vsync, va: u_if.video_activado,
                tick: u_if.instante_pulso, fe: u_if.frame_end, x: u_if.pixel_x,
                y: u_if.pixel_y, fc: u_if.frame_count};
      checks++;
      if (m_act !== m_exp) begin
        failures++;
        $display("FAIL timing @%0t got x=%0d y=%0d hs=%b vs=%b va=%b tick=%b fe=%b fc=%0d exp x=%0d y=%0d hs=%b vs=%b va=%b tick=%b fe=%b fc=%0d",
                 $time, m_act.x, m_act.y, m_act.hs, m_act.vs, m_act.va, m_act.tick, m_act.fe,
                 m_act.fc, m_exp.x, m_exp.y, m_exp.hs, m_exp.vs, m_exp.va, m_exp.tick,
                 m_exp.fe, m_exp.fc);
      end
    end
  end

  initial begin
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    run(3 * FRAME * TD + 5);

    // Reset mid-line, mid-tick-count: pixel (6,1) with the divider at 1.
    reset_pulse(0);
    run((1 * HT + 6) * TD + 1 - 1);
    reset_pulse(1);

    // Long run across the 8-bit frame-count wrap.
    run(257 * FRAME * TD + 10);

    for (int i = 0; i < 6; i++) begin
      reset_pulse($urandom_range(0, 2));
      run($urandom_range(1, 2 * FRAME * TD));
    end
    reset_pulse(0);
    run(FRAME * TD + 3);

    @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
